// File: rtl/spectrum_pkg.sv
// Shared definitions for the spectrum frame buffer: default sizes, widths,
// the fill/swap state enum and the magnitude-to-height helper.
package spectrum_pkg;

  localparam int N_BINS_DEFAULT = 256;
  localparam int HEIGHT_W       = 9;
  localparam int MAG_W          = 16;
  localparam int RD_ADDR_W      = 8;

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } fb_state_t;

  // Scale a magnitude down and clamp it to the bar ceiling. The compare is
  // done on the full shifted width so large magnitudes cannot wrap into a
  // small bar after truncation.
  function automatic logic [HEIGHT_W-1:0] clamp_height(
    input logic [MAG_W-1:0]    mag,
    input int                  shift,
    input logic [HEIGHT_W-1:0] ceiling
  );
    logic [MAG_W-1:0] shifted;
    shifted = mag >> shift;
    if (shifted > MAG_W'(ceiling)) begin
      clamp_height = ceiling;
    end else begin
      clamp_height = shifted[HEIGHT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/spectrum_dpram.sv
// Simple dual-port RAM holding both frame banks. The bank bit is the address
// MSB, so each bank is 2**(AW-1) entries. One write port, one registered
// read port, no reset on the storage or the read register.
module spectrum_dpram #(
  parameter int DW    = 9,
  parameter int AW    = 9,
  parameter int DEPTH = 2 ** AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_q
);

  logic [DW-1:0] mem [DEPTH];

  // Write port: store one bar height per accepted beat.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: one cycle of latency from address to data.
  always_ff @(posedge clk) begin
    rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/spectrum_frame_buffer.sv
// Double-buffered spectrum bar store between an FFT magnitude stream and a
// video renderer. The writer fills the back bank; on the first vsync falling
// edge after a complete frame the banks swap and the renderer sees the new
// frame. Optional feature macro: SPECTRUM_PEAK_EN enables tracking of the
// frame maximum (peak_bin/peak_val); without it both outputs are tied to 0.
module spectrum_frame_buffer
  import spectrum_pkg::*;
#(
  parameter int                  N_BINS     = N_BINS_DEFAULT,
  parameter int                  MAG_SHIFT  = 7,
  parameter logic [HEIGHT_W-1:0] MAX_HEIGHT = 9'd400
) (
  input  logic                 clk_pixel,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [MAG_W-1:0]     s_mag,
  input  logic                 s_last,
  input  logic                 vsync,
  input  logic [RD_ADDR_W-1:0] rd_addr,
  output logic [HEIGHT_W-1:0]  rd_data,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic [RD_ADDR_W-1:0] peak_bin,
  output logic [HEIGHT_W-1:0]  peak_val
);

  localparam int              IDX_W    = (N_BINS > 1) ? $clog2(N_BINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

  fb_state_t             state;
  fb_state_t             state_next;
  logic [IDX_W-1:0]      wr_idx;
  logic                  front_sel;
  logic                  vsync_q;
  logic                  rd_ok;
  logic                  accept;
  logic                  frame_done;
  logic                  frame_abort;
  logic                  vsync_fall;
  logic                  swap;
  logic [HEIGHT_W-1:0]   beat_height;
  logic [IDX_W:0]        ram_wr_addr;
  logic [IDX_W:0]        ram_rd_addr;
  logic [HEIGHT_W-1:0]   ram_q;

  // s_ready depends on the state register only, keeping the handshake free
  // of combinational paths from s_valid.
  assign s_ready     = (state == FILL);
  assign accept      = s_valid && (state == FILL);
  assign frame_done  = accept && (wr_idx == LAST_IDX);
  assign frame_abort = accept && s_last && (wr_idx != LAST_IDX);
  assign vsync_fall  = vsync_q && !vsync;
  assign swap        = (state == WAIT_SWAP) && vsync_fall;
  assign beat_height = clamp_height(s_mag, MAG_SHIFT, MAX_HEIGHT);

  // Writes always go to the bank the renderer is not reading.
  assign ram_wr_addr = {~front_sel, wr_idx};
  assign ram_rd_addr = {front_sel, rd_addr[IDX_W-1:0]};

  // State register for the fill / wait-for-swap sequencer.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a completed frame parks the writer until vsync swaps banks.
  // A frame that completes on the same edge as the vsync fall is still in
  // FILL at that edge, so it naturally waits for the following fall.
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (frame_done) begin
          state_next = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        if (vsync_fall) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Write index and sticky framing error: wrap on a full frame or an early
  // s_last, flag any disagreement between s_last and the bin count.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      frame_err <= 1'b0;
    end else if (accept) begin
      if (frame_done || frame_abort) begin
        wr_idx <= '0;
      end else begin
        wr_idx <= wr_idx + IDX_W'(1);
      end
      if ((frame_done && !s_last) || frame_abort) begin
        frame_err <= 1'b1;
      end
    end
  end

  // vsync edge history and bank swap; frame_valid latches on first swap.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b1;
      front_sel   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (swap) begin
        front_sel   <= ~front_sel;
        frame_valid <= 1'b1;
      end
    end
  end

  // Read qualifier aligned with the RAM read register: suppresses data
  // before the first frame and for addresses beyond the bin range.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      rd_ok <= 1'b0;
    end else begin
      rd_ok <= frame_valid && (32'(rd_addr) < 32'(N_BINS));
    end
  end

  assign rd_data = rd_ok ? ram_q : '0;

  spectrum_dpram #(
    .DW (HEIGHT_W),
    .AW (IDX_W + 1)
  ) u_ram (
    .clk     (clk_pixel),
    .we      (accept),
    .wr_addr (ram_wr_addr),
    .wr_data (beat_height),
    .rd_addr (ram_rd_addr),
    .rd_q    (ram_q)
  );

`ifdef SPECTRUM_PEAK_EN
  logic [IDX_W-1:0]    run_bin;
  logic [HEIGHT_W-1:0] run_val;

  // Running maximum of the back frame; bin 0 restarts it and a strict
  // greater-than keeps the first index on ties.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      run_bin <= '0;
      run_val <= '0;
    end else if (accept) begin
      if (wr_idx == '0) begin
        run_bin <= '0;
        run_val <= beat_height;
      end else if (beat_height > run_val) begin
        run_bin <= wr_idx;
        run_val <= beat_height;
      end
    end
  end

  // Publish the back-frame maximum when that frame becomes the front.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      peak_bin <= '0;
      peak_val <= '0;
    end else if (swap) begin
      peak_bin <= RD_ADDR_W'(run_bin);
      peak_val <= run_val;
    end
  end
`else
  assign peak_bin = '0;
  assign peak_val = '0;
`endif

endmodule
